// File: rtl/des_host_driver.sv
// rtl/des_host_driver.sv - sequences one DES operation over the wrapper's 32-bit host bus.
// Optional ready timeout built when DES_DRV_TIMEOUT_EN is defined.
module des_host_driver #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_key,
    input  logic [63:0] req_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic [31:0] data_bus,
    output logic [1:0]  selector,
    output logic        load,
    output logic        start,
    output logic        result_sel,
    input  logic [31:0] result_out,
    input  logic        ready,
    output logic        timeout_err
);

    typedef enum logic [2:0] {
        IDLE, LOAD, START, WAIT_CLR, WAIT_DONE, READ_HI, READ_LO, RESP
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [63:0] key_q, key_d;
    logic [63:0] data_q, data_d;
    logic [63:0] rsp_data_q, rsp_data_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] data_bus_q, data_bus_d;
    logic [1:0]  selector_q, selector_d;
    logic        load_q, load_d;
    logic        start_q, start_d;
    logic        result_sel_q, result_sel_d;

`ifdef DES_DRV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_q, tmo_d;
    logic          timeout_err_q, timeout_err_d;
`endif

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        key_d        = key_q;
        data_d       = data_q;
        rsp_data_d   = rsp_data_q;
`ifdef DES_DRV_TIMEOUT_EN
        tmo_d         = tmo_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req_valid && req_ready_q) begin
                    state_d = LOAD;
                    cnt_d   = 2'd0;
                    key_d   = req_key;
                    data_d  = req_data;
                end
            end
            LOAD: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd3) state_d = START;
            end
            START:     state_d = WAIT_CLR;
            // ready may still be high from the previous op; wait for the wrapper to drop it
            WAIT_CLR:  if (!ready) state_d = WAIT_DONE;
            WAIT_DONE: if (ready) state_d = READ_HI;
            READ_HI: begin
                rsp_data_d[63:32] = result_out;
                state_d           = READ_LO;
            end
            READ_LO: begin
                rsp_data_d[31:0] = result_out;
                state_d          = RESP;
            end
            RESP:      if (rsp_ready) state_d = IDLE;
            default:   state_d = IDLE;
        endcase

`ifdef DES_DRV_TIMEOUT_EN
        if (state_q == START) begin
            tmo_d = '0;
        end else if (state_q == WAIT_CLR || state_q == WAIT_DONE) begin
            tmo_d = tmo_q + 1'b1;
            if (tmo_q == TW'(TIMEOUT_CYCLES - 1) && !(state_q == WAIT_DONE && ready)) begin
                state_d       = IDLE;
                timeout_err_d = 1'b1;
            end
        end
`endif

        // Outputs are registered, so they are decoded from the state being entered.
        req_ready_d  = (state_d == IDLE);
        rsp_valid_d  = (state_d == RESP);
        load_d       = (state_d == LOAD);
        start_d      = (state_d == START);
        result_sel_d = (state_d == READ_LO);
        selector_d   = 2'd0;
        data_bus_d   = 32'd0;
        if (state_d == LOAD) begin
            selector_d = cnt_d;
            case (cnt_d)
                2'd0:    data_bus_d = key_d[31:0];
                2'd1:    data_bus_d = key_d[63:32];
                2'd2:    data_bus_d = data_d[31:0];
                default: data_bus_d = data_d[63:32];
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            key_q        <= 64'd0;
            data_q       <= 64'd0;
            rsp_data_q   <= 64'd0;
            req_ready_q  <= 1'b1;
            rsp_valid_q  <= 1'b0;
            data_bus_q   <= 32'd0;
            selector_q   <= 2'd0;
            load_q       <= 1'b0;
            start_q      <= 1'b0;
            result_sel_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            key_q        <= key_d;
            data_q       <= data_d;
            rsp_data_q   <= rsp_data_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            data_bus_q   <= data_bus_d;
            selector_q   <= selector_d;
            load_q       <= load_d;
            start_q      <= start_d;
            result_sel_q <= result_sel_d;
        end
    end

`ifdef DES_DRV_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q         <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_q         <= tmo_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    // Waits are unbounded in this build; the pulse can never fire.
    assign timeout_err = (TIMEOUT_CYCLES < 0);
`endif

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign data_bus   = data_bus_q;
    assign selector   = selector_q;
    assign load       = load_q;
    assign start      = start_q;
    assign result_sel = result_sel_q;

endmodule

// File: doc/des_host_driver.md
DES_HOST_DRIVER -- requirements
Module: des_host_driver

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, max wait cycles for ready (used only when DES_DRV_TIMEOUT_EN is defined).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have ports req_valid input 1, req_ready output 1: request handshake.
REQ-005 SHALL have ports req_key input 64 and req_data input 64: key and plaintext/ciphertext block.
REQ-006 SHALL have ports rsp_valid output 1, rsp_ready input 1: response handshake.
REQ-007 SHALL have port rsp_data  output  64  assembled DES result.
REQ-008 SHALL have ports data_bus output 32, selector output 2, load output 1, start output 1, result_sel output 1: drive the DES wrapper's host bus.
REQ-009 SHALL have ports result_out input 32 and ready input 1: from the DES wrapper.
REQ-010 SHALL have port timeout_err  output  1  one-cycle pulse on ready timeout.

Function
REQ-011 All outputs SHALL be registered.
REQ-012 FSM states SHALL be IDLE, LOAD, START, WAIT_CLR, WAIT_DONE, READ_HI, READ_LO, RESP.
REQ-013 req_ready SHALL be 1 only in IDLE; a request is accepted on req_valid&&req_ready, latching req_key/req_data; next state LOAD.
REQ-014 LOAD SHALL last exactly 4 cycles with load=1 and a 2-bit word counter: selector 0/1/2/3 with data_bus = key[31:0], key[63:32], data[31:0], data[63:32] respectively.
REQ-015 Outside LOAD, load SHALL be 0 and data_bus SHALL be 0.
REQ-016 START SHALL last 1 cycle with start=1; start SHALL be 0 in all other states.
REQ-017 WAIT_CLR SHALL hold until ready==0 (stale ready from a previous operation is ignored), then go to WAIT_DONE.
REQ-018 WAIT_DONE SHALL hold until ready==1, then go to READ_HI.
REQ-019 READ_HI SHALL drive result_sel=0 and capture result_out into rsp_data[63:32]; READ_LO SHALL drive result_sel=1 and capture rsp_data[31:0]; result_sel SHALL be 0 otherwise.
REQ-020 The captures SHALL account for the registered result_sel, so each half is sampled in the cycle its select is valid at the wrapper.
REQ-021 RESP SHALL assert rsp_valid and hold rsp_data stable until rsp_ready==1, then return to IDLE. No new request is accepted in the same cycle.
REQ-022 req_valid SHALL be ignored while not in IDLE; req_key/req_data changes mid-operation SHALL not affect the operation.
REQ-023 With the matched wrapper (3-cycle internal delay), rsp_valid SHALL first assert 12 cycles after the acceptance edge, given rsp_ready held high.

Reset
REQ-024 On rst=1 at a clock edge, the FSM SHALL enter IDLE, aborting any operation with no response.
REQ-025 On reset, outputs SHALL be: req_ready=1 from the cycle after reset; rsp_valid, rsp_data, data_bus, selector, load, start, result_sel, timeout_err = 0.
REQ-026 Reset SHALL also clear the word counter, timeout counter and latched key/data.

Configuration
REQ-027 Macro DES_DRV_TIMEOUT_EN defined: a counter SHALL run in WAIT_CLR/WAIT_DONE and reset on entering WAIT_CLR.
REQ-028 With DES_DRV_TIMEOUT_EN defined, if the counter reaches TIMEOUT_CYCLES without leaving WAIT_DONE, timeout_err SHALL pulse 1 cycle and the FSM SHALL go to IDLE with no response.
REQ-029 Macro DES_DRV_TIMEOUT_EN undefined: waits SHALL be unbounded, timeout_err SHALL be tied 0, and no counter logic SHALL exist.

Verification
REQ-030 Single op with wrapper+core, FIPS key 133457799BBCDFF1, data 0123456789ABCDEF -> rsp_data 85E813540F0AB405, rsp_valid 12 cycles after accept.
REQ-031 Bus trace, key 0x1111111122222222, data 0x3333333344444444 -> load cycles show selector 0,1,2,3 with data_bus 22222222, 11111111, 44444444, 33333333; start one cycle after.
REQ-032 Back-to-back ops with ready still 1 from the prior op -> driver waits for ready low then high; second rsp_data is correct, not stale.
REQ-033 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_data stable; req_ready 0 throughout; req_valid pulses ignored.
REQ-034 rst asserted in WAIT_DONE -> next cycle IDLE, all outputs 0, no rsp_valid; subsequent op correct.
REQ-035 With DES_DRV_TIMEOUT_EN and ready stuck 0, TIMEOUT_CYCLES=16 -> timeout_err pulse exactly once, 16 cycles after WAIT_CLR entry; req_ready 1 on the next cycle.
